dut_clk_gate_ctrl: RTL and testbench
====================================

// Module: dut_clk_gate_ctrl
// PURPOSE
//  Parametrised run-control clock gate for the DUT clock domains (NutShell core and peers). Replaces the
//  single VIO-enable/single-break gate. Adds per-channel clock enables, N break sources with a sticky cause,
//  a command interface (RUN/STEP/HALT/CLEAR) with valid/ready handshake, a bounded single-step mode and a
//  count of gated (DUT-visible) cycles. Sits between the debug/VIO command path and the BUFGCE primitives.
// PARAMETERS
//  NUM_CLK  2   number of gated DUT clock outputs
//  N_BRK    4   number of break sources (bit 0 = trace buffer full)
//  STEP_W   16  width of the step-count argument
//  CNT_W    48  width of the gated-cycle counter
// PORTS
//  sys_clk      in   1        free-running source clock; all logic in this domain
//  sys_rst_n    in   1        asynchronous, active-low reset
//  cmd_valid    in   1        command present
//  cmd_ready    out  1        command accepted when cmd_valid & cmd_ready
//  cmd_op       in   2        0 RUN, 1 STEP, 2 HALT, 3 CLEAR
//  cmd_arg      in   STEP_W   STEP: cycles to run (0 treated as 1)
//  ch_en        in   NUM_CLK  static per-channel enable mask
//  brk_i        in   N_BRK    level break requests
//  brk_mask     in   N_BRK    1 = source armed
//  running      out  1        state is RUN or STEP
//  halted       out  1        state is HALT
//  brk_cause    out  N_BRK    sticky armed sources that caused a halt
//  gated_cycles out  CNT_W    count of sys_clk cycles with gate open
//  clk_en       out  NUM_CLK  gate enable per channel (to BUFGCE CE)
//  dut_clk      out  NUM_CLK  gated clocks
// BEHAVIOUR
//  Reset: state=HALT, halted=1, running=0, cmd_ready=0 (1 from first cycle after reset release),
//   brk_cause=0, gated_cycles=0, step counter=0, clk_en=0.
//  brk_hit = |(brk_i & brk_mask) (combinational).
//  gate_open = (state==RUN | state==STEP) & ~brk_hit; clk_en[i] = gate_open & ch_en[i].
//   Break path is combinational: gate closes in the SAME sys_clk cycle a break asserts (zero-latency stop).
//  States / transitions (on sys_clk rising edge):
//   HALT: RUN cmd -> RUN; STEP cmd -> STEP, step_cnt=max(cmd_arg,1); HALT cmd -> no-op; CLEAR -> brk_cause=0,
//     gated_cycles=0, stay HALT.
//   RUN: brk_hit -> HALT, brk_cause |= brk_i&brk_mask; HALT cmd -> HALT; STEP cmd -> STEP reloads step_cnt;
//     RUN/CLEAR cmd ignored (accepted, no effect except CLEAR clears brk_cause/gated_cycles).
//   STEP: each gate_open cycle step_cnt--; when step_cnt==1 & gate_open -> HALT next edge (exactly N open
//     cycles); brk_hit -> HALT with cause latched, step_cnt preserved; HALT cmd -> HALT; RUN cmd -> RUN.
//  cmd_ready = 1 in all states after reset; every command accepted in one cycle.
//  Entering RUN/STEP with brk_hit still active: state changes but gate stays closed; next edge -> HALT
//   (brk_cause updated). Software must CLEAR/mask before resuming.
//  Simultaneous: brk_hit has priority over any command in the same cycle; CLEAR concurrent with a new break
//   leaves brk_cause = new break bits.
//  gated_cycles increments when gate_open (independent of ch_en); wraps modulo 2^CNT_W, no saturation.
//  Reset mid-RUN: gates close asynchronously with sys_rst_n low (clk_en forced 0).
//  ch_en changes take effect combinationally; masked channels never pulse.
// STRUCTURE
//  Shared package dut_ctrl_pkg: cmd_op encodings (CMD_RUN/STEP/HALT/CLEAR), state typedef/localparams
//   (ST_HALT/ST_RUN/ST_STEP).
//  One sub-module: dut_clk_buf (one BUFGCE per channel, generate loop, I=sys_clk, CE=clk_en[i]).
//  No VIO inside this block; VIO/debug bridge drives the cmd interface externally.
// TESTING
//  1 Reset release, no cmd, 20 cycles -> halted=1, clk_en=0, dut_clk flat, gated_cycles=0.
//  2 STEP cmd_arg=5, ch_en=2'b11 -> exactly 5 dut_clk pulses per channel, halted=1 after, gated_cycles=5.
//  3 RUN, at cycle 10 brk_i=4'b0001 masked in -> clk_en=0 same cycle, halted next edge, brk_cause=4'b0001,
//    gated_cycles=10.
//  4 RUN with brk_mask=0, brk_i=4'b1111 -> keeps running; then CLEAR+brk on same cycle -> brk_cause=new bits.
//  5 STEP cmd_arg=0 -> 1 pulse; ch_en=2'b01 -> dut_clk[1] never toggles.
//  6 sys_rst_n low mid-RUN for 3 cycles -> clk_en=0 immediately, all outputs at reset values, HALT on release.

Source files
------------

// File: rtl/dut_ctrl_pkg.sv
// rtl/dut_ctrl_pkg.sv - shared encodings for the DUT run-control clock gate
package dut_ctrl_pkg;

   typedef enum logic [1:0] {
      CMD_RUN   = 2'd0,
      CMD_STEP  = 2'd1,
      CMD_HALT  = 2'd2,
      CMD_CLEAR = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

   // RUN and STEP both let DUT clocks through unless a break is pending
   function automatic logic is_active(input state_e s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction

endpackage

// File: rtl/dut_clk_buf.sv
// rtl/dut_clk_buf.sv - one glitch-free clock gate per DUT channel (BUFGCE behaviour)
module dut_clk_buf #(
   parameter int NUM_CLK = 2
) (
   input  logic               sys_clk,
   input  logic [NUM_CLK-1:0] clk_en,
   output logic [NUM_CLK-1:0] dut_clk
);

   for (genvar i = 0; i < NUM_CLK; i++) begin : g_buf
      logic ce_l;

      // enable is captured while the source clock is low so a high phase is never cut short
      always_latch begin
         if (!sys_clk) ce_l = clk_en[i];
      end

      assign dut_clk[i] = sys_clk & ce_l;
   end

endmodule

// File: rtl/dut_clk_gate_ctrl.sv
// rtl/dut_clk_gate_ctrl.sv - run/step/halt clock gate with break sources and gated-cycle counter
module dut_clk_gate_ctrl
   import dut_ctrl_pkg::*;
#(
   parameter int NUM_CLK = 2,
   parameter int N_BRK   = 4,
   parameter int STEP_W  = 16,
   parameter int CNT_W   = 48
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [STEP_W-1:0]  cmd_arg,
   input  logic [NUM_CLK-1:0] ch_en,
   input  logic [N_BRK-1:0]   brk_i,
   input  logic [N_BRK-1:0]   brk_mask,
   output logic               running,
   output logic               halted,
   output logic [N_BRK-1:0]   brk_cause,
   output logic [CNT_W-1:0]   gated_cycles,
   output logic [NUM_CLK-1:0] clk_en,
   output logic [NUM_CLK-1:0] dut_clk
);

   state_e              state;
   logic [STEP_W-1:0]   step_cnt;
   logic [STEP_W-1:0]   step_load;
   logic [N_BRK-1:0]    brk_hits;
   logic                brk_hit;
   logic                busy;
   logic                gate_open;
   logic                cmd_acc;
   logic                clr;
   cmd_op_e             op;

   assign op        = cmd_op_e'(cmd_op);
   assign brk_hits  = brk_i & brk_mask;
   assign brk_hit   = |brk_hits;
   assign busy      = is_active(state);
   // break and reset act combinationally so the gate shuts in the cycle they appear
   assign gate_open = busy & ~brk_hit & sys_rst_n;
   assign clk_en    = ch_en & {NUM_CLK{gate_open}};
   assign cmd_acc   = cmd_valid & cmd_ready;
   assign clr       = cmd_acc & (op == CMD_CLEAR);
   assign step_load = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
   assign running   = busy;
   assign halted    = (state == ST_HALT);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_HALT;
         step_cnt <= '0;
      end else begin
         case (state)
            ST_HALT: begin
               if (cmd_acc) begin
                  case (op)
                     CMD_RUN:  state <= ST_RUN;
                     CMD_STEP: begin
                        state    <= ST_STEP;
                        step_cnt <= step_load;
                     end
                     default:  state <= ST_HALT;
                  endcase
               end
            end
            ST_RUN: begin
               if (brk_hit) begin
                  state <= ST_HALT;
               end else if (cmd_acc && op == CMD_HALT) begin
                  state <= ST_HALT;
               end else if (cmd_acc && op == CMD_STEP) begin
                  state    <= ST_STEP;
                  step_cnt <= step_load;
               end
            end
            ST_STEP: begin
               // a break leaves step_cnt untouched so the remaining budget stays visible
               if (brk_hit) begin
                  state <= ST_HALT;
               end else if (cmd_acc && op == CMD_HALT) begin
                  state <= ST_HALT;
               end else if (cmd_acc && op == CMD_RUN) begin
                  state <= ST_RUN;
               end else if (cmd_acc && op == CMD_STEP) begin
                  step_cnt <= step_load;
               end else if (gate_open) begin
                  step_cnt <= step_cnt - STEP_W'(1);
                  if (step_cnt < STEP_W'(2)) state <= ST_HALT;
               end
            end
            default: state <= ST_HALT;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cmd_ready    <= 1'b0;
         brk_cause    <= '0;
         gated_cycles <= '0;
      end else begin
         cmd_ready <= 1'b1;
         if (clr) begin
            gated_cycles <= '0;
         end else if (gate_open) begin
            gated_cycles <= gated_cycles + CNT_W'(1);
         end
         // a break landing with CLEAR replaces the old cause rather than merging into it
         if (busy && brk_hit) begin
            brk_cause <= (clr ? '0 : brk_cause) | brk_hits;
         end else if (clr) begin
            brk_cause <= '0;
         end
      end
   end

   dut_clk_buf #(
      .NUM_CLK (NUM_CLK)
   ) u_clk_buf (
      .sys_clk (sys_clk),
      .clk_en  (clk_en),
      .dut_clk (dut_clk)
   );

endmodule

// File: tb/tb_dut_clk_gate_ctrl.sv
// tb/tb_dut_clk_gate_ctrl.sv - self-checking bench for dut_clk_gate_ctrl
module tb_dut_clk_gate_ctrl;
   localparam logic [1:0] OP_RUN = 2'd0, OP_STEP = 2'd1, OP_HALT = 2'd2, OP_CLEAR = 2'd3;
   localparam int MODE_IDLE = 0, MODE_FREE = 1, MODE_COUNTED = 2;
   localparam longint unsigned CNT_MASK = (64'd1 << 48) - 64'd1;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [15:0] cmd_arg = 16'd0;
   logic [1:0]  ch_en = 2'b00;
   logic [3:0]  brk_i = 4'h0;
   logic [3:0]  brk_mask = 4'h0;
   logic        running, halted;
   logic [3:0]  brk_cause;
   logic [47:0] gated_cycles;
   logic [1:0]  clk_en, dut_clk;

   int errors = 0;
   int checks = 0;
   int p0 = 0, p1 = 0;

   int              m_mode;
   int              m_left;
   logic [3:0]      m_cause;
   longint unsigned m_cnt;
   bit              m_ready;
   int              m_p0 = 0, m_p1 = 0;

   typedef struct {
      logic        v;
      logic [1:0]  op;
      logic [15:0] arg;
      logic [1:0]  ch;
      logic [3:0]  brk;
      logic [3:0]  mask;
      logic [1:0]  exp_en;
      logic        exp_halted;
      logic [3:0]  exp_cause;
   } vec_t;
   vec_t vecs[14];

   dut_clk_gate_ctrl u_dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_arg      (cmd_arg),
      .ch_en        (ch_en),
      .brk_i        (brk_i),
      .brk_mask     (brk_mask),
      .running      (running),
      .halted       (halted),
      .brk_cause    (brk_cause),
      .gated_cycles (gated_cycles),
      .clk_en       (clk_en),
      .dut_clk      (dut_clk)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge dut_clk[0]) p0++;
   always @(posedge dut_clk[1]) p1++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = MODE_IDLE;
      m_left  = 0;
      m_cause = 4'h0;
      m_cnt   = 0;
      m_ready = 1'b0;
   endtask

   function automatic bit model_open();
      return sys_rst_n && (m_mode != MODE_IDLE) && ((brk_i & brk_mask) == 4'h0);
   endfunction

   // Behavioural rules: breaks beat commands, commands beat step countdown
   task automatic model_edge();
      logic [3:0] hits;
      bit busy, open, acc;
      hits = brk_i & brk_mask;
      busy = (m_mode != MODE_IDLE);
      open = model_open();
      acc  = cmd_valid && m_ready;
      if (open && ch_en[0]) m_p0++;
      if (open && ch_en[1]) m_p1++;
      if (acc && cmd_op == OP_CLEAR) begin
         m_cnt   = 0;
         m_cause = 4'h0;
      end else if (open) begin
         m_cnt = (m_cnt + 1) & CNT_MASK;
      end
      if (busy && hits != 4'h0) begin
         m_cause = m_cause | hits;
         m_mode  = MODE_IDLE;
      end else if (acc && cmd_op == OP_RUN) begin
         m_mode = MODE_FREE;
      end else if (acc && cmd_op == OP_STEP) begin
         m_mode = MODE_COUNTED;
         m_left = (cmd_arg == 16'd0) ? 1 : int'(cmd_arg);
      end else if (acc && cmd_op == OP_HALT) begin
         m_mode = MODE_IDLE;
      end else if (m_mode == MODE_COUNTED && open) begin
         m_left--;
         if (m_left == 0) m_mode = MODE_IDLE;
      end
      m_ready = 1'b1;
   endtask

   // entered just after a falling edge; leaves just after the next falling edge
   task automatic cyc(input logic v, input logic [1:0] op, input logic [15:0] arg,
                      input logic [1:0] ch, input logic [3:0] brk, input logic [3:0] mask,
                      output logic [1:0] en_seen);
      cmd_valid = v;
      cmd_op    = op;
      cmd_arg   = arg;
      ch_en     = ch;
      brk_i     = brk;
      brk_mask  = mask;
      #1;
      en_seen = clk_en;
      chk("clk_en", clk_en, model_open() ? ch : 2'b00);
      chk("cmd_ready", cmd_ready, m_ready);
      @(posedge sys_clk);
      model_edge();
      @(negedge sys_clk);
      chk("running", running, m_mode != MODE_IDLE);
      chk("halted", halted, m_mode == MODE_IDLE);
      chk("brk_cause", brk_cause, m_cause);
      chk("gated_cycles", gated_cycles, m_cnt);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_running"}, running, 0);
      chk({tag, "_halted"}, halted, 1);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_clk_en"}, clk_en, 0);
      chk({tag, "_brk_cause"}, brk_cause, 0);
      chk({tag, "_gated"}, gated_cycles, 0);
   endtask

   initial begin
      logic [1:0] en;
      int p0s, p1s;

      vecs[0]  = '{1'b1, OP_RUN,   16'd0, 2'b11, 4'h0, 4'hF, 2'b00, 1'b0, 4'h0};
      vecs[1]  = '{1'b0, OP_RUN,   16'd0, 2'b01, 4'h0, 4'hF, 2'b01, 1'b0, 4'h0};
      vecs[2]  = '{1'b0, OP_RUN,   16'd0, 2'b10, 4'h4, 4'hB, 2'b10, 1'b0, 4'h0};
      vecs[3]  = '{1'b0, OP_RUN,   16'd0, 2'b10, 4'h4, 4'hF, 2'b00, 1'b1, 4'h4};
      vecs[4]  = '{1'b1, OP_CLEAR, 16'd0, 2'b10, 4'h0, 4'hF, 2'b00, 1'b1, 4'h0};
      vecs[5]  = '{1'b1, OP_STEP,  16'd2, 2'b11, 4'h0, 4'hF, 2'b00, 1'b0, 4'h0};
      vecs[6]  = '{1'b0, OP_RUN,   16'd0, 2'b11, 4'h0, 4'hF, 2'b11, 1'b0, 4'h0};
      vecs[7]  = '{1'b0, OP_RUN,   16'd0, 2'b11, 4'h0, 4'hF, 2'b11, 1'b1, 4'h0};
      vecs[8]  = '{1'b0, OP_RUN,   16'd0, 2'b11, 4'h0, 4'hF, 2'b00, 1'b1, 4'h0};
      vecs[9]  = '{1'b1, OP_STEP,  16'd3, 2'b11, 4'h0, 4'hF, 2'b00, 1'b0, 4'h0};
      vecs[10] = '{1'b0, OP_RUN,   16'd0, 2'b11, 4'h8, 4'h8, 2'b00, 1'b1, 4'h8};
      vecs[11] = '{1'b1, OP_RUN,   16'd0, 2'b11, 4'h8, 4'h8, 2'b00, 1'b0, 4'h8};
      vecs[12] = '{1'b0, OP_RUN,   16'd0, 2'b11, 4'h8, 4'h8, 2'b00, 1'b1, 4'h8};
      vecs[13] = '{1'b1, OP_CLEAR, 16'd0, 2'b11, 4'h0, 4'h8, 2'b00, 1'b1, 4'h0};

      model_reset();
      repeat (2) @(negedge sys_clk);
      chk_reset("rst0");
      sys_rst_n = 1'b1;

      // idle after reset: nothing moves
      repeat (20) cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'h0, 4'h0, en);
      chk("t1_halted", halted, 1);
      chk("t1_pulses", longint'(p0 + p1), 0);
      chk("t1_gated", gated_cycles, 0);

      // STEP 5 on both channels
      p0s = p0; p1s = p1;
      cyc(1'b1, OP_STEP, 16'd5, 2'b11, 4'h0, 4'hF, en);
      repeat (7) cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'h0, 4'hF, en);
      chk("t2_pulses_ch0", longint'(p0 - p0s), 5);
      chk("t2_pulses_ch1", longint'(p1 - p1s), 5);
      chk("t2_halted", halted, 1);
      chk("t2_gated", gated_cycles, 5);

      // RUN then trace-full break after 10 open cycles
      cyc(1'b1, OP_CLEAR, 16'd0, 2'b11, 4'h0, 4'hF, en);
      cyc(1'b1, OP_RUN, 16'd0, 2'b11, 4'h0, 4'hF, en);
      repeat (10) cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'h0, 4'hF, en);
      cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'h1, 4'hF, en);
      chk("t3_clk_en_same_cycle", en, 0);
      chk("t3_halted", halted, 1);
      chk("t3_brk_cause", brk_cause, 4'h1);
      chk("t3_gated", gated_cycles, 10);

      // unarmed breaks ignored; CLEAR with a new break replaces the old cause
      cyc(1'b1, OP_RUN, 16'd0, 2'b11, 4'hF, 4'h0, en);
      repeat (8) cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'hF, 4'h0, en);
      chk("t4_running", running, 1);
      chk("t4_gated", gated_cycles, 18);
      cyc(1'b1, OP_CLEAR, 16'd0, 2'b11, 4'hF, 4'h6, en);
      chk("t4_brk_cause_new", brk_cause, 4'h6);
      chk("t4_halted", halted, 1);

      // STEP 0 acts as 1; channel 1 masked
      cyc(1'b1, OP_CLEAR, 16'd0, 2'b01, 4'h0, 4'h0, en);
      p0s = p0; p1s = p1;
      cyc(1'b1, OP_STEP, 16'd0, 2'b01, 4'h0, 4'h0, en);
      repeat (4) cyc(1'b0, OP_RUN, 16'd0, 2'b01, 4'h0, 4'h0, en);
      chk("t5_pulses_ch0", longint'(p0 - p0s), 1);
      chk("t5_pulses_ch1", longint'(p1 - p1s), 0);
      chk("t5_halted", halted, 1);
      chk("t5_gated", gated_cycles, 1);

      // asynchronous reset while running
      cyc(1'b1, OP_RUN, 16'd0, 2'b11, 4'h0, 4'hF, en);
      cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'h4, 4'hF, en);
      cyc(1'b1, OP_RUN, 16'd0, 2'b11, 4'h0, 4'hF, en);
      repeat (5) cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'h0, 4'hF, en);
      chk("t6_running_before", running, 1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk_reset("t6_now");
      p0s = p0; p1s = p1;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk_reset("t6_hold");
      chk("t6_no_pulses", longint'((p0 - p0s) + (p1 - p1s)), 0);
      sys_rst_n = 1'b1;
      model_reset();
      cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'h0, 4'hF, en);
      cyc(1'b0, OP_RUN, 16'd0, 2'b11, 4'h0, 4'hF, en);
      chk("t6_ready_after", cmd_ready, 1);

      // table vectors
      cyc(1'b1, OP_CLEAR, 16'd0, 2'b11, 4'h0, 4'h0, en);
      for (int i = 0; i < 14; i++) begin
         cyc(vecs[i].v, vecs[i].op, vecs[i].arg, vecs[i].ch, vecs[i].brk, vecs[i].mask, en);
         chk($sformatf("vec%0d_clk_en", i), en, vecs[i].exp_en);
         chk($sformatf("vec%0d_halted", i), halted, vecs[i].exp_halted);
         chk($sformatf("vec%0d_brk_cause", i), brk_cause, vecs[i].exp_cause);
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic       rv;
         logic [1:0] rop, rch;
         logic [3:0] rbrk, rmask;
         logic [15:0] rarg;
         rv    = ($urandom_range(0, 2) == 0);
         rop   = 2'($urandom_range(0, 3));
         rarg  = 16'($urandom_range(0, 6));
         rch   = 2'($urandom_range(0, 3));
         rbrk  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         rmask = 4'($urandom_range(0, 15));
         cyc(rv, rop, rarg, rch, rbrk, rmask, en);
      end
      chk("total_pulses_ch0", longint'(p0), longint'(m_p0));
      chk("total_pulses_ch1", longint'(p1), longint'(m_p1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
